// File: rtl/reg_check_sequencer.sv
// rtl/reg_check_sequencer.sv - resets a CPU, runs it, then checks registers against an expected table
module reg_check_sequencer #(
    parameter int XLEN          = 32,
    parameter int REG_AW        = 5,
    parameter int NUM_CHECKS    = 8,
    parameter int RESET_CYCLES  = 2,
    parameter int RUN_CYCLES    = 100,
    parameter int HALT_REQUIRED = 0,
    localparam int IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1,
    localparam int FW = $clog2(NUM_CHECKS + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              halt,
    input  logic              tbl_wr_en,
    input  logic [IW-1:0]     tbl_wr_idx,
    input  logic [REG_AW-1:0] tbl_wr_reg,
    input  logic [XLEN-1:0]   tbl_wr_val,
    input  logic              tbl_wr_vld,
    output logic              dut_resetn,
    output logic [REG_AW-1:0] reg_rd_addr,
    input  logic [XLEN-1:0]   reg_rd_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [FW-1:0]     fail_count,
    output logic [IW-1:0]     first_fail_idx,
    output logic [XLEN-1:0]   first_fail_got
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST_DUT,
        S_RUN,
        S_CHECK,
        S_DONE
    } state_t;

    // One shared phase counter; it must hold the longest of the three phases.
    localparam int MAXC = (RUN_CYCLES > RESET_CYCLES)
                          ? ((RUN_CYCLES > NUM_CHECKS) ? RUN_CYCLES : NUM_CHECKS)
                          : ((RESET_CYCLES > NUM_CHECKS) ? RESET_CYCLES : NUM_CHECKS);
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] RUN_LAST = CW'(RUN_CYCLES - 1);
    localparam logic [CW-1:0] CHK_LAST = CW'(NUM_CHECKS - 1);
    localparam logic [IW:0]   NCHK     = (IW + 1)'(NUM_CHECKS);

    state_t            state;
    state_t            nxt;
    logic [CW-1:0]     cnt;
    logic [IW-1:0]     ci;
    logic              launch;
    logic              tbl_we;
    logic              limit_hit;
    logic              mismatch;

    logic              tbl_vld [NUM_CHECKS];
    logic [REG_AW-1:0] tbl_reg [NUM_CHECKS];
    logic [XLEN-1:0]   tbl_val [NUM_CHECKS];

    assign ci        = cnt[IW-1:0];
    assign launch    = ((state == S_IDLE) || (state == S_DONE)) && start;
    assign busy      = (state == S_RST_DUT) || (state == S_RUN) || (state == S_CHECK);
    assign done      = (state == S_DONE);
    assign dut_resetn = (state == S_RUN) || (state == S_CHECK) || (state == S_DONE);
    assign tbl_we    = tbl_wr_en && !busy && ({1'b0, tbl_wr_idx} < NCHK);
    assign limit_hit = (state == S_RUN) && (cnt == RUN_LAST);
    assign mismatch  = (state == S_CHECK) && tbl_vld[ci] && (reg_rd_data != tbl_val[ci]);
    assign reg_rd_addr = (state == S_CHECK) ? tbl_reg[ci] : '0;
    assign pass      = done && (fail_count == '0) && !((HALT_REQUIRED != 0) && timeout);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= nxt;
    end

    // Phase sequencing; halt takes priority over the run-length limit.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) nxt = S_RST_DUT;
            S_RST_DUT:      if (cnt == RST_LAST) nxt = S_RUN;
            S_RUN:          if (halt || cnt == RUN_LAST) nxt = S_CHECK;
            S_CHECK:        if (cnt == CHK_LAST) nxt = S_DONE;
            default:        nxt = S_IDLE;
        endcase
    end

    // Phase counter restarts at zero on every state change.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)            cnt <= '0;
        else if (nxt != state)  cnt <= '0;
        else                    cnt <= cnt + 1'b1;
    end

    // Entry valid bits are cleared by reset, so a reset empties the table.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CHECKS; i++) tbl_vld[i] <= 1'b0;
        end else if (tbl_we) begin
            tbl_vld[tbl_wr_idx] <= tbl_wr_vld;
        end
    end

    // Entry payload; only meaningful while the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_reg[tbl_wr_idx] <= tbl_wr_reg;
            tbl_val[tbl_wr_idx] <= tbl_wr_val;
        end
    end

    // Run results: cleared on launch, accumulated during RUN and CHECK.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timeout        <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
        end else if (launch) begin
            timeout        <= 1'b0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            first_fail_got <= '0;
        end else begin
            if (limit_hit && !halt) timeout <= 1'b1;
            if (mismatch) begin
                fail_count <= fail_count + 1'b1;
                if (fail_count == '0) begin
                    first_fail_idx <= ci;
                    first_fail_got <= reg_rd_data;
                end
            end
        end
    end

endmodule
